// File: rtl/alu_issue_pkg.sv
// Shared core definitions for the ALU issue stage: opcodes, widths and FSM states.
package alu_issue_pkg;
  localparam int REG_W  = 6;
  localparam int XLEN   = 32;
  localparam int CTL_W  = 6;
  localparam int CNT_W  = 16;

  localparam logic [CTL_W-1:0] ALU_ADD    = 6'd0;
  localparam logic [CTL_W-1:0] ALU_SUB    = 6'd1;
  localparam logic [CTL_W-1:0] ALU_AND    = 6'd2;
  localparam logic [CTL_W-1:0] ALU_OR     = 6'd3;
  localparam logic [CTL_W-1:0] ALU_XOR    = 6'd4;
  localparam logic [CTL_W-1:0] ALU_SLL    = 6'd5;
  localparam logic [CTL_W-1:0] ALU_SRL    = 6'd6;
  localparam logic [CTL_W-1:0] ALU_SRA    = 6'd7;
  localparam logic [CTL_W-1:0] ALU_SLT    = 6'd8;
  localparam logic [CTL_W-1:0] ALU_SLTU   = 6'd9;
  localparam logic [CTL_W-1:0] ALU_MUL    = 6'd16;
  localparam logic [CTL_W-1:0] ALU_DIV    = 6'd17;
  localparam logic [CTL_W-1:0] ALU_FDIV   = 6'd20;
  localparam logic [CTL_W-1:0] ALU_BUBBLE = 6'b111111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Per-source operand selection: zero register, then EX bypass, then WB bypass, then RF.
module fwd_mux
  import alu_issue_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic [XLEN-1:0]  i_rf_val,
  input  logic             i_ex_valid,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic [XLEN-1:0]  i_ex_data,
  input  logic             i_wb_valid,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic [XLEN-1:0]  o_operand
);
  // Checking rs==0 first also keeps ex_rd==0 / wb_rd==0 from ever bypassing.
  always_comb begin
    o_operand = i_rf_val;
    if (i_rs == '0)
      o_operand = '0;
    else if (i_ex_valid && (i_rs == i_ex_rd))
      o_operand = i_ex_data;
    else if (i_wb_valid && (i_rs == i_wb_rd))
      o_operand = i_wb_data;
  end
endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: registers decode into EX with operand forwarding, tracks EX/WB tags,
// and holds the pipeline while a multi-cycle ALU operation is pending.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [CTL_W-1:0] id_aluctl,
  input  logic [REG_W-1:0] id_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [XLEN-1:0]  id_rs1_val,
  input  logic [XLEN-1:0]  id_rs2_val,
  input  logic             id_use_imm,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  alu_fwd,
  input  logic             alu_stall,
  input  logic [XLEN-1:0]  wb_res,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [CTL_W-1:0] aluctl,
  output logic             stall,
  output logic             ex_valid,
  output logic             wb_valid,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic [CNT_W-1:0] stall_cnt
);
  state_e           r_state;
  state_e           w_state_next;
  logic [XLEN-1:0]  r_op1, r_op2;
  logic [CTL_W-1:0] r_aluctl;
  logic             r_ex_valid, r_wb_valid;
  logic [REG_W-1:0] r_ex_rd, r_wb_rd;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_stall;
  logic             w_bubble;
  logic [REG_W-1:0] w_rs  [2];
  logic [XLEN-1:0]  w_rf  [2];
  logic [XLEN-1:0]  w_opnd[2];

  assign w_stall  = alu_stall & r_ex_valid & ~flush;
  assign w_bubble = ~id_valid | flush;

  assign w_rs[0] = id_rs1;
  assign w_rs[1] = id_rs2;
  assign w_rf[0] = id_rs1_val;
  assign w_rf[1] = id_rs2_val;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      fwd_mux u_fwd_mux (
        .i_rs       (w_rs[gi]),
        .i_rf_val   (w_rf[gi]),
        .i_ex_valid (r_ex_valid),
        .i_ex_rd    (r_ex_rd),
        .i_ex_data  (alu_fwd),
        .i_wb_valid (r_wb_valid),
        .i_wb_rd    (r_wb_rd),
        .i_wb_data  (wb_res),
        .o_operand  (w_opnd[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_stall) w_state_next = ST_WAIT;
      ST_WAIT: if (!w_stall || flush) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_op1       <= '0;
      r_op2       <= '0;
      r_aluctl    <= ALU_BUBBLE;
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (!w_stall) begin
        if (w_bubble) begin
          r_op1      <= '0;
          r_op2      <= '0;
          r_aluctl   <= ALU_BUBBLE;
          r_ex_valid <= 1'b0;
          r_ex_rd    <= '0;
        end else begin
          r_op1      <= w_opnd[0];
          r_op2      <= id_use_imm ? id_imm : w_opnd[1];
          r_aluctl   <= id_aluctl;
          r_ex_valid <= 1'b1;
          r_ex_rd    <= id_rd;
        end
        // A flushed EX instruction must not retire into WB.
        r_wb_valid <= r_ex_valid & ~flush;
        r_wb_rd    <= r_ex_rd;
      end
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall     = w_stall;
  assign id_ready  = ~w_stall;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign aluctl    = r_aluctl;
  assign ex_valid  = r_ex_valid;
  assign ex_rd     = r_ex_rd;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed hazard scenarios followed by random traffic.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready, id_use_imm, alu_stall;
  logic [5:0]  id_aluctl, id_rd, id_rs1, id_rs2, aluctl, ex_rd, wb_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm, alu_fwd, wb_res, op1, op2;
  logic        stall, ex_valid, wb_valid;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_aluctl(id_aluctl), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_use_imm(id_use_imm),
    .id_imm(id_imm), .alu_fwd(alu_fwd), .alu_stall(alu_stall), .wb_res(wb_res),
    .op1(op1), .op2(op2), .aluctl(aluctl), .stall(stall), .ex_valid(ex_valid),
    .wb_valid(wb_valid), .ex_rd(ex_rd), .wb_rd(wb_rd), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        chk_comb;
    logic        stall;
    logic [31:0] op1, op2;
    logic [5:0]  ctl, ex_rd, wb_rd;
    logic        ex_valid, wb_valid;
    logic [15:0] cnt;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Reference model: architectural view of what sits in EX and WB.
  logic        m_known = 1'b0;
  logic [31:0] m_op1, m_op2;
  logic [5:0]  m_ctl, m_ex_rd, m_wb_rd;
  logic        m_ex_valid = 1'b0, m_wb_valid = 1'b0;
  logic [15:0] m_cnt;

  function automatic logic [31:0] pick(input logic [5:0] rs, input logic [31:0] rf,
                                       input logic [31:0] fwd, input logic [31:0] wbr);
    if (rs == 6'd0) return 32'd0;
    if (m_ex_valid && rs == m_ex_rd) return fwd;
    if (m_wb_valid && rs == m_wb_rd) return wbr;
    return rf;
  endfunction

  task automatic issue(input logic r, input logic f, input logic v, input logic as,
                       input logic [5:0] ctl, input logic [5:0] rd, input logic [5:0] rs1,
                       input logic [5:0] rs2, input logic [31:0] v1, input logic [31:0] v2,
                       input logic ui, input logic [31:0] imm, input logic [31:0] fwd,
                       input logic [31:0] wbr);
    exp_t e;
    logic st;
    @(negedge clk);
    rst = r; flush = f; id_valid = v; alu_stall = as; id_aluctl = ctl; id_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_val = v1; id_rs2_val = v2; id_use_imm = ui;
    id_imm = imm; alu_fwd = fwd; wb_res = wbr;
    #1;
    st = as & m_ex_valid & ~f;
    e.chk_comb = m_known;
    e.stall = st;
    e.id = n_txn;
    n_txn++;
    if (r) begin
      m_op1 = 0; m_op2 = 0; m_ctl = 6'h3F; m_ex_valid = 0; m_ex_rd = 0;
      m_wb_valid = 0; m_wb_rd = 0; m_cnt = 0;
    end else begin
      if (st) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end else begin
        logic [31:0] a, b;
        a = pick(rs1, v1, fwd, wbr);
        b = ui ? imm : pick(rs2, v2, fwd, wbr);
        m_wb_valid = m_ex_valid & ~f;
        m_wb_rd = m_ex_rd;
        if (!v || f) begin
          m_op1 = 0; m_op2 = 0; m_ctl = 6'h3F; m_ex_valid = 0; m_ex_rd = 0;
        end else begin
          m_op1 = a; m_op2 = b; m_ctl = ctl; m_ex_valid = 1; m_ex_rd = rd;
        end
      end
    end
    m_known = 1'b1;
    e.op1 = m_op1; e.op2 = m_op2; e.ctl = m_ctl; e.ex_rd = m_ex_rd; e.wb_rd = m_wb_rd;
    e.ex_valid = m_ex_valid; e.wb_valid = m_wb_valid; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  // Shorthand for an ordinary register-register instruction.
  task automatic op(input logic as, input logic f, input logic [5:0] ctl, input logic [5:0] rd,
                    input logic [5:0] rs1, input logic [5:0] rs2, input logic [31:0] v1,
                    input logic [31:0] v2, input logic [31:0] fwd, input logic [31:0] wbr);
    issue(1'b0, f, 1'b1, as, ctl, rd, rs1, rs2, v1, v2, 1'b0, 32'd0, fwd, wbr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int id);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s txn %0d: got %h want %h", name, id, act, exp);
    end
  endtask

  // Monitor: combinational stall before the edge, registered state after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0 && q[0].chk_comb) begin
        chk("stall", {31'd0, stall}, {31'd0, q[0].stall}, q[0].id);
        chk("id_ready", {31'd0, id_ready}, {31'd0, ~q[0].stall}, q[0].id);
      end
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("op1", op1, e.op1, e.id);
        chk("op2", op2, e.op2, e.id);
        chk("aluctl", {26'd0, aluctl}, {26'd0, e.ctl}, e.id);
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.ex_valid}, e.id);
        chk("ex_rd", {26'd0, ex_rd}, {26'd0, e.ex_rd}, e.id);
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.wb_valid}, e.id);
        chk("wb_rd", {26'd0, wb_rd}, {26'd0, e.wb_rd}, e.id);
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt}, e.id);
        $display("txn %0d ctl=%h op1=%h op2=%h exv=%b exrd=%0d wbv=%b wbrd=%0d cnt=%0d",
                 e.id, aluctl, op1, op2, ex_valid, ex_rd, wb_valid, wb_rd, stall_cnt);
      end
    end
  end

  initial begin
    issue(1, 0, 0, 0, 6'd0, 6'd0, 6'd0, 6'd0, 0, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 1, 6'd1, 6'd2, 6'd0, 6'd0, 0, 0, 0, 0, 0, 0);
    // back-to-back dependency through alu_fwd
    op(0, 0, 6'd0, 6'd3, 6'd1, 6'd2, 32'd1, 32'd2, 32'h11, 32'h22);
    op(0, 0, 6'd0, 6'd4, 6'd3, 6'd3, 32'd99, 32'd98, 32'd3, 32'h22);
    // WB forwarding, then EX beating WB for the same rd
    op(0, 0, 6'd0, 6'd5, 6'd1, 6'd2, 32'd7, 32'd8, 32'h0, 32'h0);
    op(0, 0, 6'd1, 6'd6, 6'd1, 6'd2, 32'd7, 32'd8, 32'h0, 32'h0);
    op(0, 0, 6'd0, 6'd1, 6'd5, 6'd6, 32'd1, 32'd2, 32'h66, 32'h55);
    op(0, 0, 6'd0, 6'd7, 6'd1, 6'd2, 32'd1, 32'd2, 32'h0, 32'h0);
    op(0, 0, 6'd0, 6'd7, 6'd1, 6'd2, 32'd1, 32'd2, 32'h0, 32'h0);
    op(0, 0, 6'd2, 6'd2, 6'd7, 6'd7, 32'd1, 32'd2, 32'hE7E7, 32'hB7B7);
    // fdiv held for three cycles
    op(0, 0, 6'd20, 6'd8, 6'd1, 6'd2, 32'd100, 32'd5, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) op(1, 0, 6'd0, 6'd9, 6'd8, 6'd1, 32'd1, 32'd2, 32'hF0, 32'h0);
    op(0, 0, 6'd0, 6'd9, 6'd8, 6'd1, 32'd1, 32'd2, 32'h14, 32'h0);
    // fdiv flushed in its second stall cycle
    op(0, 0, 6'd20, 6'd10, 6'd1, 6'd2, 32'd9, 32'd3, 32'h0, 32'h0);
    op(1, 0, 6'd0, 6'd11, 6'd1, 6'd2, 32'd1, 32'd2, 32'h0, 32'h0);
    op(1, 1, 6'd0, 6'd11, 6'd1, 6'd2, 32'd1, 32'd2, 32'h0, 32'h0);
    op(0, 0, 6'd0, 6'd12, 6'd10, 6'd1, 32'h77, 32'd2, 32'h0, 32'h0);
    // x0 destination in EX never forwards; immediate overrides rs2
    op(0, 0, 6'd0, 6'd0, 6'd1, 6'd2, 32'd1, 32'd2, 32'h0, 32'h0);
    issue(0, 0, 1, 0, 6'd0, 6'd13, 6'd0, 6'd0, 32'h5, 32'h6, 1, 32'hFFFFF800, 32'hDEADBEEF, 32'h0);
    // reset in the middle of a multi-cycle wait
    op(0, 0, 6'd20, 6'd14, 6'd1, 6'd2, 32'd9, 32'd3, 32'h0, 32'h0);
    op(1, 0, 6'd0, 6'd15, 6'd1, 6'd2, 32'd1, 32'd2, 32'h0, 32'h0);
    issue(1, 0, 1, 1, 6'd0, 6'd15, 6'd1, 6'd2, 32'd1, 32'd2, 0, 0, 0, 0);
    op(1, 0, 6'd0, 6'd15, 6'd1, 6'd2, 32'd1, 32'd2, 32'h0, 32'h0);
    op(1, 0, 6'd0, 6'd15, 6'd1, 6'd2, 32'd1, 32'd2, 32'h0, 32'h0);
    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 300; i++) begin
      issue($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            6'($urandom_range(0, 20)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            6'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3) == 0,
            $urandom, $urandom, $urandom);
    end
    repeat (3) @(posedge clk);
    #5;
    chk("queue_drained", q.size(), 32'd0, n_txn);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  kill the instruction entering or occupying EX; a bubble is issued instead.
REQ-005 id_valid  input  1  decode presents a valid ALU instruction.
REQ-006 id_ready  output  1  issue accepts the decode instruction this cycle.
REQ-007 id_aluctl  input  6  ALU operation code, same encoding the ALU consumes.
REQ-008 id_rd, id_rs1, id_rs2  input  6 each  destination/source register indices; 0 is the hard-wired zero register.
REQ-009 id_rs1_val, id_rs2_val  input  32 each  register-file read data.
REQ-010 id_use_imm  input  1  op2 is taken from id_imm instead of rs2.
REQ-011 id_imm  input  32  sign-extended immediate.
REQ-012 alu_fwd  input  32  combinational ALU result of the EX instruction.
REQ-013 alu_stall  input  1  ALU multi-cycle operation not finished.
REQ-014 wb_res  input  32  registered ALU result of the WB instruction.
REQ-015 op1, op2  output  32 each  registered ALU operands.
REQ-016 aluctl  output  6  registered ALU operation code.
REQ-017 stall  output  1  global pipeline stall, driven to the ALU stall input.
REQ-018 ex_valid, wb_valid  output  1 each  instruction valid in EX / WB.
REQ-019 ex_rd, wb_rd  output  6 each  destination register of EX / WB instruction.
REQ-020 stall_cnt  output  16  saturating count of cycles with stall high.

Function
REQ-021 stall SHALL equal alu_stall & ex_valid & ~flush (combinational).
REQ-022 id_ready SHALL equal ~stall.
REQ-023 FSM states RUN and WAIT; RUN->WAIT when stall high; WAIT->RUN when stall low or flush; WAIT->WAIT otherwise.
REQ-024 In RUN with ~stall, on clk edge: op1/op2/aluctl/ex_rd/ex_valid load from decode, ex_valid <= id_valid & ~flush.
REQ-025 In WAIT (stall high) op1, op2, aluctl, ex_rd, ex_valid, wb_rd, wb_valid SHALL hold their values unchanged.
REQ-026 Operand select per source, priority order: rs==0 -> 0; rs==ex_rd & ex_valid -> alu_fwd; rs==wb_rd & wb_valid -> wb_res; else register-file value.
REQ-027 When id_use_imm, op2 SHALL be id_imm regardless of rs2 forwarding.
REQ-028 A bubble (id_valid low or flush) SHALL load aluctl 6'b111111, op1=op2=0, ex_rd=0, ex_valid=0.
REQ-029 On each ~stall edge, wb_valid <= ex_valid and wb_rd <= ex_rd (tracks the ALU's registered wb_res exactly one cycle later).
REQ-030 flush during WAIT SHALL abort the multi-cycle op: stall drops same cycle, bubble loads at the edge, wb_valid <= 0.
REQ-031 ex_rd==0 SHALL never be a forwarding source even if ex_valid.
REQ-032 stall_cnt SHALL increment by 1 per stall cycle and saturate at 16'hFFFF.

Reset
REQ-033 rst SHALL force state RUN, op1=op2=0, aluctl=6'b111111, ex_valid=wb_valid=0, ex_rd=wb_rd=0, stall_cnt=0; rst overrides flush and stall.
REQ-034 Reset asserted mid-WAIT SHALL drop stall in the following cycle since ex_valid clears.

Structure
REQ-035 The 6-bit ALU op codes, the bubble code 6'b111111, register index width 6, and the FSM state enum SHALL live in the shared core package.
REQ-036 One sub-module fwd_mux (rs index, rf value, EX/WB tags and data -> operand) SHALL be instantiated twice.

Verification
REQ-037 Back-to-back add x3=1+2 then add x4=x3+x3 -> second op1=op2=3 via alu_fwd, no stall.
REQ-038 x5 written, one unrelated instruction, then read x5 -> operand from wb_res; same rd in EX and WB -> EX value wins.
REQ-039 fdiv (latency 3) issued with alu_stall high 3 cycles -> stall high 3 cycles, op1/op2/aluctl stable, id_ready low, stall_cnt +3.
REQ-040 flush asserted in 2nd cycle of fdiv stall -> stall low same cycle, next aluctl=6'b111111, ex_valid=0, wb_valid=0 after edge.
REQ-041 Source x0 with ex_rd=0, ex_valid=1 and alu_fwd=32'hDEADBEEF -> operand 0; id_use_imm=1, imm=32'hFFFFF800 -> op2=32'hFFFFF800.
REQ-042 rst asserted during WAIT -> all outputs at reset values next cycle, state RUN.
